// File: rtl/lcd_rgb_timing_gen.sv
// rtl/lcd_rgb_timing_gen.sv - parallel RGB565 TFT timing generator with per-frame colour/pattern latch
module lcd_rgb_timing_gen #(
  parameter int PCLK_DIV = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [4:0] color_r,
  input  logic [5:0] color_g,
  input  logic [4:0] color_b,
  output logic       lcd_dclk,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic       lcd_de,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DW      = $clog2(PCLK_DIV);
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = $clog2(BAR_W + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(PCLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_DE_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_DE_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_DE_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_DE_END  = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;
  logic [4:0]    red_q;
  logic [5:0]    green_q;
  logic [4:0]    blue_q;
  logic          tick;
  logic          adv;
  logic          h_act;
  logic          v_act;
  logic          de_cur;
  logic          frame_tick;
  logic [5:0]    ramp_g;
  logic [4:0]    pix_r;
  logic [5:0]    pix_g;
  logic [4:0]    pix_b;

  assign tick       = (div_cnt == DIV_LAST);
  assign adv        = en && tick;
  assign div_next   = tick ? '0 : div_cnt + DW'(1);
  assign h_act      = (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
  assign v_act      = (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
  assign de_cur     = h_act && v_act;
  assign frame_tick = adv && (h_cnt == '0) && (v_cnt == '0);
  // Only ax[8:3] is needed for the ramp; values outside the active window are masked by DE.
  assign ramp_g     = 6'((h_cnt - H_DE_BEG) >> 3);

  // Pixel divider; dclk is low for the first half of each pixel so data changes on its falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      lcd_dclk <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      lcd_dclk <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      lcd_dclk <= (div_next >= DIV_HALF);
    end
  end

  // Raster counters: h runs every pixel, v advances at each line wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Capture colour and mode once per frame so CPU writes never tear the picture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_tick;
      if (frame_tick) begin
        mode_q  <= mode;
        red_q   <= color_r;
        green_q <= color_g;
        blue_q  <= color_b;
      end
    end
  end

  // Colour-bar position tracked with a running counter across the active window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!en) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (tick) begin
      if (!h_act) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px  <= bar_px + BW'(1);
      end
    end
  end

  // Pattern select; bar colours follow white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_q)
      2'd0: begin
        pix_r = red_q;
        pix_g = green_q;
        pix_b = blue_q;
      end
      2'd1: begin
        pix_r = {5{~bar_idx[1]}};
        pix_g = {6{~bar_idx[2]}};
        pix_b = {5{~bar_idx[0]}};
      end
      2'd2: pix_g = ramp_g;
      default: ;
    endcase
  end

  // Panel outputs registered on the pixel tick, one pixel behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      lcd_de    <= 1'b0;
      lcd_r     <= '0;
      lcd_g     <= '0;
      lcd_b     <= '0;
    end else if (!en) begin
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      lcd_de    <= 1'b0;
      lcd_r     <= '0;
      lcd_g     <= '0;
      lcd_b     <= '0;
    end else if (tick) begin
      lcd_hsync <= (h_cnt >= H_SYNC_E);
      lcd_vsync <= (v_cnt >= V_SYNC_E);
      lcd_de    <= de_cur;
      lcd_r     <= de_cur ? pix_r : 5'd0;
      lcd_g     <= de_cur ? pix_g : 6'd0;
      lcd_b     <= de_cur ? pix_b : 5'd0;
    end
  end

endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// tb/tb_lcd_rgb_timing_gen.sv - directed self-checking bench for lcd_rgb_timing_gen on a reduced raster
module tb_lcd_rgb_timing_gen;

  localparam int PD  = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int VA  = 3;
  localparam int VFP = 1;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int FRAME_CLKS = HT * VT * PD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [1:0] mode;
  logic [4:0] color_r;
  logic [5:0] color_g;
  logic [4:0] color_b;
  logic       lcd_dclk;
  logic       lcd_hsync;
  logic       lcd_vsync;
  logic       lcd_de;
  logic [4:0] lcd_r;
  logic [5:0] lcd_g;
  logic [4:0] lcd_b;
  logic       frame_start;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int fs_cyc     = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  lcd_rgb_timing_gen #(
    .PCLK_DIV(PD), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .lcd_dclk(lcd_dclk), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_de(lcd_de), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dclk"},  32'(lcd_dclk), 32'd0);
    chk({tag, "_hsync"}, 32'(lcd_hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(lcd_vsync), 32'd1);
    chk({tag, "_de"},    32'(lcd_de), 32'd0);
    chk({tag, "_rgb"},   32'({lcd_r, lcd_g, lcd_b}), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
  endtask

  task automatic chk_start(input string tag);
    chk({tag, "_dclk"},  32'(lcd_dclk), 32'd1);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_hsync"}, 32'(lcd_hsync), 32'd1);
  endtask

  // Advance to the middle of the next pixel (dclk high); bounded so a stuck dclk cannot hang.
  task automatic next_pix();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lcd_dclk !== 1'b1 && n < 4);
    chk("pix_dclk", 32'(lcd_dclk), 32'd1);
  endtask

  function automatic bit exp_de(input int h, input int v);
    return (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
  endfunction

  function automatic logic [15:0] exp_rgb(input logic [1:0] m, input logic [4:0] r,
                                          input logic [5:0] g, input logic [4:0] b,
                                          input int h, input int v);
    int ax;
    if (!exp_de(h, v)) return 16'h0000;
    ax = h - (HS + HBP);
    case (m)
      2'd0:    return {r, g, b};
      2'd1:    return bars[ax / (HA / 8)];
      2'd2:    return {5'd0, 6'(ax / 8), 5'd0};
      default: return 16'h0000;
    endcase
  endfunction

  // Walk one full frame from its frame_start pulse; inputs switch to n* values mid-frame.
  task automatic scan_frame(input logic [1:0] em, input logic [4:0] er, input logic [5:0] eg,
                            input logic [4:0] eb, input logic [1:0] nm, input logic [4:0] nr,
                            input logic [5:0] ng, input logic [4:0] nb, input bit chk_period);
    int de_line;
    int de_total;
    int first_de;
    @(negedge clk);
    chk("frame_start", 32'(frame_start), 32'd1);
    if (chk_period) chk("frame_period", cyc - fs_cyc, FRAME_CLKS);
    fs_cyc = cyc;
    de_total = 0;
    for (int v = 0; v < VT; v++) begin
      de_line  = 0;
      first_de = -1;
      for (int h = 0; h < HT; h++) begin
        next_pix();
        if (v * HT + h == 80) begin
          mode = nm; color_r = nr; color_g = ng; color_b = nb;
        end
        chk("hsync", 32'(lcd_hsync), 32'(h >= HS));
        chk("vsync", 32'(lcd_vsync), 32'(v >= VS));
        chk("de", 32'(lcd_de), 32'(exp_de(h, v)));
        chk("rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(exp_rgb(em, er, eg, eb, h, v)));
        chk("fs_low", 32'(frame_start), 32'd0);
        if (lcd_de === 1'b1) begin
          de_line++;
          if (first_de < 0) first_de = h;
        end
      end
      if (v >= VS + VBP && v < VS + VBP + VA) begin
        chk("de_per_line", de_line, HA);
        chk("first_de_offset", first_de, HS + HBP);
      end
      de_total += de_line;
    end
    chk("de_per_frame", de_total, HA * VA);
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    mode    = 2'd0;
    color_r = 5'd0;
    color_g = 6'd0;
    color_b = 5'd0;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle("en_low");

    color_r = 5'd31; color_g = 6'd0; color_b = 5'd5; mode = 2'd0;
    en = 1'b1;
    @(negedge clk);
    chk_start("first_start");
    scan_frame(2'd0, 5'd31, 6'd0,  5'd5, 2'd0, 5'd31, 6'd63, 5'd5, 1'b0);
    scan_frame(2'd0, 5'd31, 6'd63, 5'd5, 2'd1, 5'd31, 6'd63, 5'd5, 1'b1);
    scan_frame(2'd1, 5'd31, 6'd63, 5'd5, 2'd2, 5'd31, 6'd63, 5'd5, 1'b1);
    scan_frame(2'd2, 5'd31, 6'd63, 5'd5, 2'd2, 5'd31, 6'd63, 5'd5, 1'b1);

    @(negedge clk);
    chk("fs_before_drop", 32'(frame_start), 32'd1);
    repeat (84) next_pix();
    chk("mid_de", 32'(lcd_de), 32'd1);
    chk("mid_ramp_g", 32'(lcd_g), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk_idle("en_drop");
    repeat (3) @(negedge clk);
    chk_idle("en_hold");
    en = 1'b1;
    @(negedge clk);
    chk_start("en_resume");
    scan_frame(2'd2, 5'd31, 6'd63, 5'd5, 2'd3, 5'd31, 6'd63, 5'd5, 1'b0);

    repeat (30) next_pix();
    #2 reset_n = 1'b0;
    #1 chk_idle("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_start("reset_resume");
    scan_frame(2'd3, 5'd31, 6'd63, 5'd5, 2'd3, 5'd31, 6'd63, 5'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_rgb_timing_gen.md
Name: lcd_rgb_timing_gen

Overview:
- Downstream consumer of the LCD colour PIO registers: red (5 b), green (6 b), blue (5 b).
- Generates parallel RGB565 panel timing (DCLK, HSYNC, VSYNC, DE) for the 480x272 TFT.
- Drives pixel data: either the PIO colour or a built-in test pattern.
- Colour and mode are sampled once per frame, so CPU writes never tear mid-frame.

Parameters:
- PCLK_DIV, 2, clk cycles per pixel; even, >=2.
- H_SYNC, 41, hsync width in pixels.
- H_BP, 2, horizontal back porch in pixels.
- H_ACTIVE, 480, visible pixels per line; must be a multiple of 8.
- H_FP, 2, horizontal front porch in pixels.
- V_SYNC, 10, vsync width in lines.
- V_BP, 2, vertical back porch in lines.
- V_ACTIVE, 272, visible lines.
- V_FP, 2, vertical front porch in lines.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  timing enable; low holds the block idle.
- mode  in  2  pattern: 0 solid colour, 1 colour bars, 2 green ramp, 3 black.
- color_r  in  5  solid red, from PIO.
- color_g  in  6  solid green, from PIO.
- color_b  in  5  solid blue, from PIO.
- lcd_dclk  out  1  panel pixel clock.
- lcd_hsync  out  1  active-low line sync.
- lcd_vsync  out  1  active-low frame sync.
- lcd_de  out  1  data enable, high on visible pixels.
- lcd_r  out  5  red data.
- lcd_g  out  6  green data.
- lcd_b  out  5  blue data.
- frame_start  out  1  one-clk pulse at the first pixel tick of each frame.

Behaviour:
- Clocking: single clock domain; reset is asynchronous, active-low.
- Reset values: div_cnt=0, h_cnt=0, v_cnt=0, lcd_dclk=0, lcd_hsync=1, lcd_vsync=1, lcd_de=0, rgb=0, frame_start=0, latched colour/mode=0.
- Divider: div_cnt counts 0..PCLK_DIV-1 and wraps. tick = (div_cnt==PCLK_DIV-1). lcd_dclk = 1 while div_cnt >= PCLK_DIV/2, registered. All panel outputs change only on tick, i.e. when dclk falls, so they are stable at the dclk rising edge.
- Counters: h_cnt runs 0..H_TOTAL-1 with H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. v_cnt runs 0..V_TOTAL-1 (same construction). On tick h_cnt increments; at wrap h_cnt goes to 0 and v_cnt increments; v_cnt wraps to 0 at V_TOTAL-1.
- Line order: sync, back porch, active, front porch; frame order is the same.
- Decode: hsync_n = !(h_cnt < H_SYNC). vsync_n = !(v_cnt < V_SYNC). de = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- Latency: outputs are registered on tick from the current counter values. Sync, DE and data all lag the counters by exactly one pixel, so they stay mutually aligned.
- Frame latch: on the tick where h_cnt=0 and v_cnt=0, latch color_r/g/b and mode, and assert frame_start for that clk only. Input changes at any other time have no effect until the next frame.
- Active x index ax = h_cnt-(H_SYNC+H_BP).
- Pattern, mode 0: latched colour.
- Pattern, mode 1: 8 vertical bars, each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black (full-scale channels: r=31, g=63, b=31). Bar index comes from a running counter, no divider.
- Pattern, mode 2: r=0, b=0, g=ax[8:3].
- Pattern, mode 3: all zero.
- Blanking: rgb=0 whenever de=0.
- Enable: en=0 synchronously forces the counters and div_cnt to 0 and holds the outputs at their reset values. en 0->1 starts a fresh frame; frame_start appears after PCLK_DIV clks.
- Reset mid-frame: all state returns immediately to reset values; the next frame starts from h=0, v=0.

Test Plan:
- Reset, then en=1 with defaults -> frame_start period is 525*286*2 = 300300 clk; lcd_hsync low for 41 pixels per 525; lcd_vsync low for 10 lines per 286.
- DE count -> exactly 480 DE-high ticks per visible line, 272 visible lines per frame; first DE follows hsync fall by 43 pixels; rgb=0 while DE low.
- Mode 0, color=(r 31, g 0, b 5); change color_g to 63 mid-frame -> current frame stays 31/0/5, the next frame shows 31/63/5.
- Mode 1, H_ACTIVE=16, small porches -> pixel pairs show FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (RGB565).
- Mode 2 -> lcd_g steps 0,0..0(x8),1..., reaching 59 at ax=472..479.
- en dropped mid-line, or reset_n pulsed mid-frame -> outputs at reset values within 1 clk (async for reset); resume gives frame_start after PCLK_DIV clks and correct timing thereafter.
